// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first,
//                with start/busy/done handshake and held registered result.
//                Define OVERFLOW_FLAG_EN to enable the signed overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int              c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    logic               w_accept;
    logic               w_last;
    logic               w_diff;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;

    assign w_accept   = (r_state == c_ST_IDLE) && start;
    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_diff     = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    assign w_br_next  = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (w_last) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_br   <= bin;
            r_cnt  <= '0;
        end else if (r_state == c_ST_SHIFT) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_br   <= w_br_next;
            r_res  <= w_res_next;
            r_cnt  <= r_cnt + 1'b1;
            // Final bit: publish the completed result together with its borrow
            if (w_last) begin
                r_d    <= w_res_next;
                r_bout <= w_br_next;
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if ((r_state == c_ST_SHIFT) && w_last) begin
            // w_diff is the MSB of the final difference on the last bit-cycle
            r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);
    assign d    = r_d;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Scoreboard bench for serial_subtractor with an arithmetic
//                reference model; honours OVERFLOW_FLAG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int c_W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [c_W-1:0] a = '0;
    logic [c_W-1:0] b = '0;
    logic           bin = 1'b0;
    logic           busy;
    logic           done;
    logic [c_W-1:0] d;
    logic           bout;
    logic           ovf;

    serial_subtractor #(.WIDTH(c_W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .d    (d),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_W-1:0] d;
        logic           bout;
        logic           ovf;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    logic [c_W-1:0] hold_d = '0;
    logic           hold_bout = 1'b0;
    logic           hold_ovf = 1'b0;
    logic           prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [c_W-1:0] ma, input logic [c_W-1:0] mb,
                                   input logic mbin, input int done_cyc);
        exp_t e;
        int   ud;
        int   sa;
        int   sbv;
        int   sd;
        ud     = int'(ma) - int'(mb) - int'(mbin);
        e.d    = c_W'(ud);
        e.bout = (ud < 0);
        sa     = $signed(ma);
        sbv    = $signed(mb);
        sd     = sa - sbv - int'(mbin);
`ifdef OVERFLOW_FLAG_EN
        e.ovf  = (sd > (2 ** (c_W - 1)) - 1) || (sd < -(2 ** (c_W - 1)));
`else
        e.ovf  = 1'b0;
        if (sd == 0) e.ovf = 1'b0;
`endif
        e.cyc  = done_cyc;
        return e;
    endfunction

    // Monitor: pops expectations when done is presented, checks hold otherwise
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (prev_done) check("done_width", 2, 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("d", int'(d), int'(e.d));
                    check("bout", int'(bout), int'(e.bout));
                    check("ovf", int'(ovf), int'(e.ovf));
                    check("done_latency", cyc, e.cyc);
                    hold_d    = e.d;
                    hold_bout = e.bout;
                    hold_ovf  = e.ovf;
                end
            end else begin
                check("hold", int'({d, bout, ovf}), int'({hold_d, hold_bout, hold_ovf}));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // mode 0: normal, 1: start re-pulsed mid-SHIFT, 2: reset two cycles after accept
    task automatic run_op(input logic [c_W-1:0] ta, input logic [c_W-1:0] tb,
                          input logic tbin, input int mode);
        int guard;
        int nbusy;
        guard = 0;
        while (busy && guard < 50) begin
            tick();
            guard++;
        end
        if (busy) check("idle_timeout", 1, 0);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        sb.push_back(model(ta, tb, tbin, cyc + 1 + c_W));
        tick();
        start = 1'b0;
        a     = c_W'($urandom);
        b     = c_W'($urandom);
        bin   = 1'($urandom);
        nbusy = busy ? 1 : 0;
        if (mode == 1) begin
            start = 1'b1;
            a     = '1;
            b     = '0;
            tick();
            start = 1'b0;
            if (busy) nbusy++;
        end
        if (mode == 2) begin
            tick();
            reset = 1'b1;
            sb.delete();
            tick();
            reset     = 1'b0;
            hold_d    = '0;
            hold_bout = 1'b0;
            hold_ovf  = 1'b0;
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            check("abort_d", int'(d), 0);
            check("abort_bout", int'(bout), 0);
            check("abort_ovf", int'(ovf), 0);
        end else begin
            guard = 0;
            while (busy && guard < 50) begin
                tick();
                if (busy) nbusy++;
                guard++;
            end
            check("busy_cycles", nbusy, c_W + 1);
        end
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d", int'(d), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_ovf", int'(ovf), 0);
        tick();

        run_op(4'b0111, 4'b0011, 1'b0, 0);
        run_op(4'b0011, 4'b0101, 1'b0, 0);
        run_op(4'b1000, 4'b0001, 1'b0, 0);
        run_op(4'b0101, 4'b0001, 1'b1, 0);
        run_op(4'b0000, 4'b0001, 1'b0, 0);
        run_op(4'b0110, 4'b0010, 1'b0, 1);
        run_op(4'b0000, 4'b0000, 1'b1, 0);
        run_op(4'b1111, 4'b1111, 1'b1, 0);
        run_op(4'b0000, 4'b1000, 1'b0, 0);
        run_op(4'b0010, 4'b0011, 1'b0, 2);
        run_op(4'b1001, 4'b0100, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(c_W'($urandom), c_W'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
